// File: rtl/mbist_pkg.sv
// Shared types for the MBIST fail logger: controller state encoding and the
// per-failure record layout buffered for the test host.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } logger_state_e;

  localparam int REC_ADDR_W = 8;
  localparam int REC_DATA_W = 8;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] xor_mask;
  } fail_rec_t;

endpackage

// File: rtl/mbist_fail_logger_if.sv
// Bundle between the MBIST controller/comparator/host (master) and the fail
// logger (slave). dbg_state mirrors the logger FSM for observation.
interface mbist_fail_logger_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  import mbist_pkg::*;

  // cmp_valid is a strobe with no backpressure; the log read side is
  // valid/ready: a record leaves the FIFO on a rising edge where both
  // log_valid and log_rd are high, and log_rd alone has no effect.
  logic              start;
  logic              cmp_valid;
  logic              eq;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_t;
  logic [DATA_W-1:0] ramout;
  logic              done;
  logic              busy;
  logic              test_done;
  logic              test_pass;
  logic              fail;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] ff_addr;
  logic [DATA_W-1:0] ff_exp;
  logic [DATA_W-1:0] ff_act;
  logic              log_rd;
  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_xor;
  logic              log_ovf;
  logger_state_e     dbg_state;

  modport master (
    output start, cmp_valid, eq, addr, data_t, ramout, done, log_rd,
    input  busy, test_done, test_pass, fail, err_count, ff_addr, ff_exp,
           ff_act, log_valid, log_addr, log_xor, log_ovf, dbg_state
  );

  modport slave (
    input  start, cmp_valid, eq, addr, data_t, ramout, done, log_rd,
    output busy, test_done, test_pass, fail, err_count, ff_addr, ff_exp,
           ff_act, log_valid, log_addr, log_xor, log_ovf, dbg_state
  );

endinterface

// File: rtl/mbist_fail_fifo.sv
// Synchronous record FIFO with synchronous clear; head is read combinationally
// from storage. A push on a full FIFO is accepted only alongside a pop.
module mbist_fail_fifo #(
  parameter int  DEPTH = 8,
  parameter type rec_t = mbist_pkg::fail_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  rec_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mbist_fail_logger.sv
// MBIST result logger: sticky fail, saturating error count, first-fail capture
// and pass/fail verdict. Define MBIST_FAIL_LOG_EN to build the fail-record FIFO.
module mbist_fail_logger
  import mbist_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int LOG_DEPTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  mbist_fail_logger_if.slave bus
);

  logger_state_e     state_q, state_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0] ff_act_q, ff_act_d;
  logic              miscmp;

  // start owns the cycle: a compare in the same cycle is discarded
  assign miscmp = (state_q == RUN) && !bus.start && bus.cmp_valid && !bus.eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fail_q    <= 1'b0;
      cnt_q     <= '0;
      ff_addr_q <= '0;
      ff_exp_q  <= '0;
      ff_act_q  <= '0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      cnt_q     <= cnt_d;
      ff_addr_q <= ff_addr_d;
      ff_exp_q  <= ff_exp_d;
      ff_act_q  <= ff_act_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fail_d    = fail_q;
    cnt_d     = cnt_q;
    ff_addr_d = ff_addr_q;
    ff_exp_d  = ff_exp_q;
    ff_act_d  = ff_act_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (!bus.start && bus.done) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (bus.start) begin
      fail_d    = 1'b0;
      cnt_d     = '0;
      ff_addr_d = '0;
      ff_exp_d  = '0;
      ff_act_d  = '0;
    end else if (miscmp) begin
      fail_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (!fail_q) begin
        ff_addr_d = bus.addr;
        ff_exp_d  = bus.data_t;
        ff_act_d  = bus.ramout;
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.test_done = (state_q == DONE);
  assign bus.test_pass = (state_q == DONE) && !fail_q;
  assign bus.fail      = fail_q;
  assign bus.err_count = cnt_q;
  assign bus.ff_addr   = ff_addr_q;
  assign bus.ff_exp    = ff_exp_q;
  assign bus.ff_act    = ff_act_q;
  assign bus.dbg_state = state_q;

`ifdef MBIST_FAIL_LOG_EN
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] xor_mask;
  } log_rec_t;

  log_rec_t push_rec, head_rec;
  logic     fifo_full, fifo_empty, log_pop;
  logic     ovf_q, ovf_d;

  assign push_rec = '{addr: bus.addr, xor_mask: bus.data_t ^ bus.ramout};
  assign log_pop  = bus.log_rd && !fifo_empty;
  assign ovf_d    = bus.start ? 1'b0 : (ovf_q || (miscmp && fifo_full && !log_pop));

  mbist_fail_fifo #(
    .DEPTH (LOG_DEPTH),
    .rec_t (log_rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.start),
    .push  (miscmp),
    .pop   (bus.log_rd),
    .wdata (push_rec),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.log_valid = !fifo_empty;
  assign bus.log_addr  = head_rec.addr;
  assign bus.log_xor   = head_rec.xor_mask;
  assign bus.log_ovf   = ovf_q;
`else
  localparam int LOG_DEPTH_UNUSED = LOG_DEPTH;
  logic log_rd_unused;
  assign log_rd_unused = bus.log_rd;
  assign bus.log_valid = 1'b0;
  assign bus.log_addr  = '0;
  assign bus.log_xor   = '0;
  assign bus.log_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Directed bench for mbist_fail_logger: queue-based reference model compared
// every cycle, plus literal expectations from the test plan.
module tb_mbist_fail_logger;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam int LOG_DEPTH = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef MBIST_FAIL_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbist_fail_logger_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mbist_fail_logger #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  bit          m_busy, m_done, m_fail, m_ovf;
  int          m_cnt;
  logic [7:0]  m_ff_addr, m_ff_exp, m_ff_act;
  logic [15:0] m_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_results();
    m_fail = 0; m_ovf = 0; m_cnt = 0;
    m_ff_addr = '0; m_ff_exp = '0; m_ff_act = '0;
    m_log.delete();
  endtask

  task automatic model_reset();
    model_clear_results();
    m_busy = 0; m_done = 0;
  endtask

  task automatic model_step();
    if (LOG_EN && bus.log_rd && m_log.size() > 0) void'(m_log.pop_front());
    if (bus.start) begin
      model_clear_results();
      m_busy = 1; m_done = 0;
    end else if (m_busy) begin
      if (bus.cmp_valid && !bus.eq) begin
        if (!m_fail) begin
          m_ff_addr = bus.addr; m_ff_exp = bus.data_t; m_ff_act = bus.ramout;
        end
        m_fail = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (LOG_EN) begin
          if (m_log.size() < LOG_DEPTH) m_log.push_back({bus.addr, bus.data_t ^ bus.ramout});
          else m_ovf = 1;
        end
      end
      if (bus.done) begin
        m_busy = 0; m_done = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] head;
    head = (m_log.size() > 0) ? m_log[0] : 16'h0;
    check("busy", bus.busy, m_busy);
    check("test_done", bus.test_done, m_done);
    check("test_pass", bus.test_pass, m_done && !m_fail);
    check("fail", bus.fail, m_fail);
    check("err_count", bus.err_count, m_cnt);
    check("ff_addr", bus.ff_addr, m_ff_addr);
    check("ff_exp", bus.ff_exp, m_ff_exp);
    check("ff_act", bus.ff_act, m_ff_act);
    check("log_valid", bus.log_valid, m_log.size() > 0);
    check("log_ovf", bus.log_ovf, m_ovf);
    if (m_log.size() > 0 || !bus.log_valid) begin
      check("log_addr", bus.log_addr, head[15:8]);
      check("log_xor", bus.log_xor, head[7:0]);
    end
  end

  // driver tasks: each call advances exactly one rising edge, ending 1ns after it
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.cmp_valid = 0; bus.eq = 1; bus.addr = '0;
    bus.data_t = '0; bus.ramout = '0; bus.done = 0; bus.log_rd = 0;
  endtask

  task automatic drive_cmp(input logic [7:0] a, input logic [7:0] e, input logic [7:0] r);
    bus.cmp_valid = 1; bus.addr = a; bus.data_t = e; bus.ramout = r; bus.eq = (e == r);
  endtask

  task automatic do_start();
    bus.start = 1; tick(); bus.start = 0;
  endtask

  task automatic do_cmp(input logic [7:0] a, input logic [7:0] e, input logic [7:0] r);
    drive_cmp(a, e, r); tick(); bus.cmp_valid = 0;
  endtask

  task automatic do_done();
    bus.done = 1; tick(); bus.done = 0;
  endtask

  task automatic do_pop();
    bus.log_rd = 1; tick(); bus.log_rd = 0;
  endtask

  task automatic drain(output int n, output logic [7:0] last);
    n = 0; last = '0;
    for (int k = 0; k < LOG_DEPTH + 4 && bus.log_valid; k++) begin
      last = bus.log_addr;
      do_pop();
      n++;
    end
  endtask

  int         n_rec;
  logic [7:0] last_addr;

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_err", bus.err_count, 0);

    // done and log_rd in IDLE are ignored
    do_done();
    do_pop();
    check("idle_done_ignored", bus.test_done, 1'b0);

    // clean run
    do_start();
    for (int i = 0; i < 16; i++) do_cmp(8'(i), 8'(i * 3), 8'(i * 3));
    do_done();
    check("clean_done", bus.test_done, 1'b1);
    check("clean_pass", bus.test_pass, 1'b1);
    check("clean_err", bus.err_count, 0);
    check("clean_log_valid", bus.log_valid, 1'b0);

    // single fail
    do_start();
    do_cmp(8'h04, 8'h11, 8'h11);
    do_cmp(8'h05, 8'hAA, 8'hA8);
    check("single_fail", bus.fail, 1'b1);
    check("single_err", bus.err_count, 1);
    check("single_ff", {bus.ff_addr, bus.ff_exp, bus.ff_act}, 24'h05AAA8);
    do_done();
    check("single_pass", bus.test_pass, 1'b0);
    check("single_done", bus.test_done, 1'b1);
`ifdef MBIST_FAIL_LOG_EN
    check("single_head", {bus.log_valid, bus.log_addr, bus.log_xor}, 17'h10502);
`else
    check("single_no_log", bus.log_valid, 1'b0);
`endif

    // first-fail hold and in-order read-out
    do_start();
    do_cmp(8'h10, 8'h11, 8'h13);
    do_cmp(8'h20, 8'h22, 8'h62);
    do_cmp(8'h30, 8'h33, 8'h30);
    check("hold_ff_addr", bus.ff_addr, 8'h10);
    check("hold_err", bus.err_count, 3);
`ifdef MBIST_FAIL_LOG_EN
    check("hold_rd0", {bus.log_addr, bus.log_xor}, 16'h1002); do_pop();
    check("hold_rd1", {bus.log_addr, bus.log_xor}, 16'h2040); do_pop();
    check("hold_rd2", {bus.log_addr, bus.log_xor}, 16'h3003); do_pop();
    check("hold_empty", bus.log_valid, 1'b0);
`endif
    do_done();

    // overflow without reads
    do_start();
    for (int i = 1; i <= 10; i++) do_cmp(8'(i), 8'hF0, 8'h0F);
`ifdef MBIST_FAIL_LOG_EN
    check("ovf_set", bus.log_ovf, 1'b1);
    drain(n_rec, last_addr);
    check("ovf_records", n_rec, 8);
    check("ovf_last", last_addr, 8'h08);
`endif

    // overflow with a pop on the 9th fail
    do_start();
    for (int i = 1; i <= 8; i++) do_cmp(8'(i), 8'h55, 8'h54);
    drive_cmp(8'h09, 8'h55, 8'h54); bus.log_rd = 1; tick(); bus.log_rd = 0; bus.cmp_valid = 0;
    check("ovf_pop_no_drop", bus.log_ovf, 1'b0);
    do_cmp(8'h0A, 8'h55, 8'h54);
`ifdef MBIST_FAIL_LOG_EN
    check("ovf_after_10th", bus.log_ovf, 1'b1);
    drain(n_rec, last_addr);
    check("ovf_pop_records", n_rec, 8);
    check("ovf_pop_last", last_addr, 8'h09);
`endif

    // saturation
    do_start();
    for (int i = 0; i < 20; i++) do_cmp(8'(i), 8'h00, 8'(i + 1));
    check("sat_err", bus.err_count, 15);

    // compare in the same cycle as start is ignored
    drive_cmp(8'h44, 8'h01, 8'h02); bus.start = 1; tick(); bus.start = 0; bus.cmp_valid = 0;
    check("start_cmp_err", bus.err_count, 0);
    check("start_cmp_fail", bus.fail, 1'b0);

    // restart mid-RUN
    for (int i = 0; i < 3; i++) do_cmp(8'(i + 1), 8'h80, 8'h00);
    do_start();
    check("restart_busy", bus.busy, 1'b1);
    check("restart_clear", {bus.fail, bus.err_count, bus.ff_addr, bus.log_valid}, 0);

    // compare coinciding with done counts toward the verdict
    drive_cmp(8'h77, 8'h0F, 8'h1F); bus.done = 1; tick(); bus.done = 0; bus.cmp_valid = 0;
    check("done_cmp_pass", bus.test_pass, 1'b0);
    check("done_cmp_err", bus.err_count, 1);
    do_cmp(8'h78, 8'h00, 8'hFF);
    check("done_state_ignores_cmp", bus.err_count, 1);

    // asynchronous reset mid-RUN
    do_start();
    do_cmp(8'h21, 8'h12, 8'h13);
    do_cmp(8'h22, 8'h12, 8'h16);
    rst_n = 0;
    model_reset();
    #1;
    check("async_rst_outs", {bus.busy, bus.fail, bus.err_count, bus.ff_addr, bus.log_valid}, 0);
    clear_inputs();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // miscompare in IDLE is ignored
    do_cmp(8'h33, 8'hAA, 8'h55);
    check("idle_cmp_fail", bus.fail, 1'b0);
    check("idle_cmp_err", bus.err_count, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
